// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational instruction memory,
// and buffers fetched {pc, inst} pairs so that decode stalls, redirects and halts lose nothing.
`timescale 1ns/1ps
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fault,
    output logic [31:0] fault_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C      = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE_C  = PW'(1'b1);
    localparam logic [32:0]   ADDR_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_pc_d   [DEPTH];
    logic [31:0]   buf_inst_q [DEPTH];
    logic [31:0]   buf_inst_d [DEPTH];

    logic          addr_bad_s;
    logic          fetch_en_s;
    logic          bad_fetch_s;
    logic          space_s;
    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] wr_idx_s;

    assign imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
    assign if_valid  = (count_q != {CW{1'b0}});
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

    // Head entry presentation; reads zero while the buffer is empty.
    always_comb begin
        if_pc   = 32'h0000_0000;
        if_inst = 32'h0000_0000;
        if (if_valid) begin
            if_pc   = buf_pc_q[rd_ptr_q];
            if_inst = buf_inst_q[rd_ptr_q];
        end else begin
            if_pc   = 32'h0000_0000;
            if_inst = 32'h0000_0000;
        end
    end

    // Fetch decision, FIFO bookkeeping, PC, fault and state next-values.
    always_comb begin
        addr_bad_s  = ({1'b0, imem_addr} >= ADDR_LIMIT) ||
                      (redirect_valid && (redirect_pc[1:0] != 2'b00));
        fetch_en_s  = !halt && (redirect_valid || (state_q == ST_RUN));
        bad_fetch_s = addr_bad_s && (redirect_valid || ((state_q == ST_RUN) && !halt));
        // A redirect flushes the buffer, so any pop that cycle is discarded.
        pop_s       = if_valid && if_ready && !redirect_valid;
        space_s     = redirect_valid || (count_q < DEPTH_C) || pop_s;
        push_s      = fetch_en_s && !addr_bad_s && space_s;
        wr_idx_s    = redirect_valid ? {PW{1'b0}} : wr_ptr_q;

        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        if (push_s) begin
            buf_pc_d[wr_idx_s]   = imem_addr;
            buf_inst_d[wr_idx_s] = imem_inst;
            pc_d                 = imem_addr + 32'd4;
        end else if (redirect_valid) begin
            pc_d = imem_addr;
        end else begin
            pc_d = pc_q;
        end

        if (redirect_valid) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = push_s ? PTR_ONE_C : {PW{1'b0}};
            count_d  = push_s ? ONE_C : {CW{1'b0}};
        end else begin
            rd_ptr_d = pop_s  ? rd_ptr_q + PTR_ONE_C : rd_ptr_q;
            wr_ptr_d = push_s ? wr_ptr_q + PTR_ONE_C : wr_ptr_q;
            if (push_s && !pop_s) begin
                count_d = count_q + ONE_C;
            end else if (pop_s && !push_s) begin
                count_d = count_q - ONE_C;
            end else begin
                count_d = count_q;
            end
        end

        if (bad_fetch_s) begin
            fault_d    = 1'b1;
            fault_pc_d = imem_addr;
        end else if (redirect_valid) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        if (redirect_valid) begin
            state_d = addr_bad_s ? ST_FAULT : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bad_fetch_s) begin
                        state_d = ST_FAULT;
                    end else if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALTED: state_d = halt ? ST_HALTED : ST_RUN;
                ST_FAULT:  state_d = ST_FAULT;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= 32'h0000_0000;
                buf_inst_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected head PCs are queued when stimulus is applied
// and popped as decode accepts them; the instruction memory returns A000_0000 | addr.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [31:0] fault_pc;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_pc;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;
    assign imem_inst = 32'hA000_0000 | imem_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; if_ready = 1'b0;
        sb.delete();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; if_ready = 1'b0;
        tick(); tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_pc); end
        checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h want 0/0", if_pc, if_inst); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_run();
        do_reset();
        if_ready = 1'b1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL run_first_valid: got %b want 0", if_valid); end
        for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_pc = sb.pop_front();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin
                errors++; $display("FAIL run_head: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", if_valid, if_pc, if_inst, exp_pc, 32'hA000_0000 | exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL stall_pre_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h10 || imem_addr !== 32'h18) begin
                errors++; $display("FAIL stall_hold: got v=%b pc=%h addr=%h want v=1 pc=10 addr=18", if_valid, if_pc, imem_addr);
            end
        end
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(32'h10 + 32'(i * 4));
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL stall_release_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_timeout: %0d left want 0", sb.size()); end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redirect_addr: got %h want 40", imem_addr); end
        tick();
        redirect_valid = 1'b0;
        sb.push_back(32'h40); sb.push_back(32'h44); sb.push_back(32'h48);
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL redirect_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL redirect_timeout: %0d left want 0", sb.size()); end
    endtask

    task automatic test_fault();
        do_reset();
        if_ready = 1'b1;
        for (int i = 0; i < 64; i++) sb.push_back(32'(i * 4));
        for (int n = 0; n < 80 && sb.size() > 0; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL fault_run_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL fault_timeout: %0d left want 0", sb.size()); end
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h100) begin errors++; $display("FAIL fault_set: got %b/%h want 1/100", fault, fault_pc); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fault_drain: got %b want 0", if_valid); end
        tick(); tick();
        checks++; if (if_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got v=%b f=%b want 0/1", if_valid, fault); end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", fault); end
        sb.push_back(32'h0); sb.push_back(32'h4);
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL fault_resume_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL fault_resume_timeout: %0d left want 0", sb.size()); end
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h20) begin errors++; $display("FAIL misalign_fault: got %b/%h want 1/20", fault, fault_pc); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL misalign_flush: got %b want 0", if_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        tick(); tick();
        halt = 1'b1; if_ready = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h08) begin errors++; $display("FAIL halt_addr: got %h want 08", imem_addr); end
        sb.push_back(32'h0); sb.push_back(32'h4);
        for (int n = 0; n < 2; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL halt_drain_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_drain: %0d left want 0", sb.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (if_valid !== 1'b0 || imem_addr !== 32'h08) begin errors++; $display("FAIL halt_hold: got v=%b addr=%h want 0/08", if_valid, imem_addr); end
            tick();
        end
        halt = 1'b0;
        sb.push_back(32'h08); sb.push_back(32'h0C); sb.push_back(32'h10);
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (if_valid && if_ready) begin
                exp_pc = sb.pop_front(); checks++;
                if (if_pc !== exp_pc || if_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL halt_resume_head: got %h/%h want %h", if_pc, if_inst, exp_pc); end
            end
            tick();
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_resume_timeout: %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL midreset_state: got v=%b f=%b want 0/0", if_valid, fault); end
        checks++; if (imem_addr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL midreset_addr: got addr=%h pc=%h want 0/0", imem_addr, if_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'hA000_0000) begin errors++; $display("FAIL midreset_first: got v=%b pc=%h inst=%h want 1/0/A0000000", if_valid, if_pc, if_inst); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_fault();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the pipelined core. It owns the program counter and drives the address of the combinational instruction memory (`inst_mem`: word-aligned `addr`, same-cycle `inst`). It buffers fetched {pc, inst} pairs in a small FIFO so that decode stalls do not lose fetches. It also handles branch/jump redirects (flush), halt, and out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
IMEM_WORDS, 64, number of valid 32-bit words in inst_mem; fetch address limit is IMEM_WORDS*4
DEPTH, 2, fetch-buffer entries; power of two, at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_addr  output  32  address to inst_mem.addr; combinational
imem_inst  input  32  data from inst_mem.inst; valid in the same cycle
if_valid  output  1  buffer head holds a valid instruction
if_ready  input  1  decode accepts the head this cycle; low means stall
if_pc  output  32  PC of the head entry
if_inst  output  32  instruction of the head entry
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  redirect target
halt  input  1  level; suppresses new fetches while high
fault  output  1  sticky out-of-range or misaligned fetch
fault_pc  output  32  PC that caused the fault

Behaviour:
- Reset (rst=1 at an edge) sets:
  - pc=RESET_PC, FIFO count=0, rd/wr pointers=0, state=RUN.
  - fault=0, fault_pc=0, if_valid=0.
  - if_pc and if_inst read 0 while empty.
- Reset has priority over every other input, including mid-redirect and mid-stall.
- States:
  - RUN: fetching normally.
  - HALTED: halt=1; no fetches.
  - FAULT: sticky; no fetches.
- Transitions:
  - RUN→HALTED when halt=1.
  - HALTED→RUN when halt=0.
  - RUN→FAULT on a bad fetch address.
  - FAULT→RUN only on redirect_valid with a good target, or on reset.
  - Any state→RUN on redirect_valid with a good target.
- Fetch address (combinational):
  - imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc.
  - Bad address: addr ≥ IMEM_WORDS*4, or redirect_pc[1:0]≠0.
- Push condition:
  - Requires state RUN (or any redirect), halt=0, address good, and space available.
  - Space means count<DEPTH, or count==DEPTH with a pop this cycle; this gives full throughput when full.
- On push:
  - Entry {imem_addr, imem_inst} is written.
  - pc <= imem_addr+4.
  - No push means pc holds, except during redirect.
- Pop: if_valid && if_ready. The head advances and count decrements. Push and pop in the same cycle leave count unchanged.
- Outputs are FIFO-registered. if_valid = (count≠0); if_pc and if_inst come from the head entry, with no combinational path from imem_inst.
- Fetch latency: an instruction fetched in cycle N is presented in cycle N+1 if the buffer was empty.
- Redirect cycle:
  - All buffered entries are discarded and a pop that cycle is ignored.
  - If the target is good and halt=0, the target is pushed at the same edge, so if_valid=1 with if_pc=target next cycle (1-cycle redirect latency).
  - If halt=1, pc <= target and nothing is pushed.
  - Redirect takes priority over halt for pc update.
- Bad address:
  - No push; fault<=1 and fault_pc<=offending address; state→FAULT.
  - Entries already buffered still drain normally.
  - A bad redirect target also flushes the buffer and faults.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - pc+4 is 32-bit modular, but the IMEM_WORDS bound faults before any wrap.
- Halt mid-stall: the buffer contents are kept and drain while halted.

Test Plan:
- Bench memory model returns inst = 32'hA000_0000 | addr.
- Reset then run, if_ready=1 → if_valid first seen the cycle after reset release; if_pc sequence 0,4,8,…; if_inst=0xA000_0000,0xA000_0004,…; one instruction per cycle.
- Stall: if_ready=0 for 5 cycles after pc=0x10 issued → count saturates at DEPTH=2; heads 0x10 then 0x14 delivered in order on release; no skipped or duplicated PC; imem_addr holds 0x18 while full.
- Redirect with 2 entries buffered, redirect_pc=0x40 and if_ready=1 → next cycle if_pc=0x40, if_inst=0xA000_0040; flushed PCs never appear; following if_pc=0x44.
- Fault: run to pc=0xFC (IMEM_WORDS=64) → 0xFC delivered, then fault=1 and fault_pc=0x100, if_valid drops after drain; redirect_pc=0x0 clears fault and resumes at 0x0. Misaligned redirect 0x22 → fault=1, fault_pc=0x20.
- Halt: assert halt at pc=0x08 for 4 cycles → buffer drains, imem_addr stays 0x08, no new pushes; on deassert, fetching resumes at 0x08.
- Reset mid-stall with a full buffer and redirect_valid=1 → next cycle if_valid=0, fault=0, imem_addr=RESET_PC.
